// File: rtl/clk_meter_pkg.sv
// Shared FSM encoding and parameter defaults for the clock-period meter.
package clk_meter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArm  = 2'd1,
      StMeas = 2'd2
   } meter_state_e;

   localparam int unsigned DefW          = 16;
   localparam int unsigned DefSyncStages = 2;
   localparam int unsigned DefLockCnt    = 4;
   localparam int unsigned DefTol        = 1;

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sync_rise_det
   import clk_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic I_CLK,
   input  logic Rst,
   input  logic I_SIG,
   output logic O_SYNC,
   output logic O_RISE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge I_CLK) begin
      if (Rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], I_SIG};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign O_SYNC = sync_q[SYNC_STAGES-1];
   assign O_RISE = O_SYNC & ~prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period of a slow asynchronous input in local clock cycles,
// with lock (stable period) and timeout (input stopped) indications.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int unsigned W           = DefW,
   parameter int unsigned SYNC_STAGES = DefSyncStages,
   parameter int unsigned LOCK_CNT    = DefLockCnt,
   parameter int unsigned TOL         = DefTol
) (
   input  logic         I_CLK,
   input  logic         Rst,
   input  logic         I_SIG,
   output logic [W-1:0] O_PERIOD,
   output logic         O_VALID,
   output logic         O_LOCK,
   output logic         O_TIMEOUT
);

   localparam int unsigned MatchW  = $clog2(LOCK_CNT + 1);
   localparam int unsigned SettleW = $clog2(SYNC_STAGES + 2);

   localparam logic [W-1:0]       CntMax    = {W{1'b1}};
   localparam logic [MatchW-1:0]  MatchMax  = MatchW'(LOCK_CNT);
   localparam logic [SettleW-1:0] SettleMax = SettleW'(SYNC_STAGES);
   localparam logic [W:0]         TolW      = (W+1)'(TOL);

   meter_state_e       state_q, state_d;
   logic [W-1:0]       cnt_q, cnt_d;
   logic [W-1:0]       period_q, period_d;
   logic [MatchW-1:0]  match_q, match_d;
   logic [SettleW-1:0] settle_q, settle_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic               first_q, first_d;

   logic              sig_sync, rise;
   logic signed [W:0] diff;
   logic [W:0]        abs_diff;
   logic              within_tol;
   logic              settled;

   sync_rise_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_rise_det (
      .I_CLK (I_CLK),
      .Rst   (Rst),
      .I_SIG (I_SIG),
      .O_SYNC(sig_sync),
      .O_RISE(rise)
   );

   assign diff       = $signed({1'b0, cnt_q}) - $signed({1'b0, period_q});
   assign abs_diff   = diff[W] ? $unsigned(-diff) : $unsigned(diff);
   assign within_tol = (abs_diff <= TolW);

   // The synchronizer reads 0 while it refills after reset, so a high input would look
   // low for SYNC_STAGES cycles; arming needs one more low sample than that.
   assign settled = !sig_sync && (settle_q == SettleMax);

   always_ff @(posedge I_CLK) begin
      if (Rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (settled) state_d = StArm;
         StArm:   if (rise) state_d = StMeas;
         StMeas:  if (!rise && (cnt_q == CntMax)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      match_d   = match_q;
      first_d   = first_q;
      settle_d  = '0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!sig_sync && (settle_q != SettleMax)) settle_d = settle_q + 1'b1;
            else if (!sig_sync) settle_d = settle_q;
         end
         StArm: begin
            if (rise) begin
               cnt_d   = W'(1);
               first_d = 1'b1;
            end
         end
         StMeas: begin
            if (rise) begin
               period_d  = cnt_q;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = W'(1);
               first_d   = 1'b0;
               // First period after arming only becomes the reference.
               if (first_q || !within_tol) match_d = '0;
               else if (match_q != MatchMax) match_d = match_q + 1'b1;
            end else if (cnt_q == CntMax) begin
               timeout_d = 1'b1;
               match_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (Rst) begin
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         match_q   <= '0;
         first_q   <= 1'b0;
         settle_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         match_q   <= match_d;
         first_q   <= first_d;
         settle_q  <= settle_d;
      end
   end

   assign O_PERIOD  = period_q;
   assign O_VALID   = valid_q;
   assign O_TIMEOUT = timeout_q;
   assign O_LOCK    = (match_q == MatchMax);

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: table vectors, randomized periods against a period/lock
// model, and hand-written timeout, saturation, reset and held-high sequences.
module tb_clk_period_meter;

   localparam int LockCnt = 4;
   localparam int Tol     = 1;

   typedef struct {
      int cyc;
      int period;
      bit lock;
      bit tmo;
   } obs_t;

   typedef struct {
      bit restart;
      int period;
      bit exp_lock;
   } vec_t;

   typedef bit bitq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sig = 1'b0;
   logic [15:0] period16;
   logic        valid16, lock16, tmo16;
   logic [7:0]  period8;
   logic        valid8, lock8, tmo8;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   gap_viol = 0;
   bit   pv16 = 1'b0, pv8 = 1'b0, pt8 = 1'b0;
   obs_t obs16[$];
   obs_t obs8[$];
   int   tmo8_rise[$];
   vec_t tbl[$];
   int   grp_p[$];
   bit   grp_l[$];
   int   grp_n;
   int   rp[$];
   int   b8, bt, b16;

   always #5 clk = ~clk;

   clk_period_meter #(
      .W(16), .SYNC_STAGES(2), .LOCK_CNT(LockCnt), .TOL(Tol)
   ) u_dut (
      .I_CLK    (clk),
      .Rst      (rst),
      .I_SIG    (sig),
      .O_PERIOD (period16),
      .O_VALID  (valid16),
      .O_LOCK   (lock16),
      .O_TIMEOUT(tmo16)
   );

   clk_period_meter #(
      .W(8), .SYNC_STAGES(2), .LOCK_CNT(LockCnt), .TOL(Tol)
   ) u_dut8 (
      .I_CLK    (clk),
      .Rst      (rst),
      .I_SIG    (sig),
      .O_PERIOD (period8),
      .O_VALID  (valid8),
      .O_LOCK   (lock8),
      .O_TIMEOUT(tmo8)
   );

   function automatic obs_t make_obs(input int c, input int p, input bit l, input bit t);
      obs_t o;
      o.cyc = c; o.period = p; o.lock = l; o.tmo = t;
      return o;
   endfunction

   function automatic vec_t mk_vec(input bit r, input int p, input bit l);
      vec_t v;
      v.restart = r; v.period = p; v.exp_lock = l;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid16) obs16.push_back(make_obs(cyc, int'(period16), lock16, tmo16));
      if (valid8) obs8.push_back(make_obs(cyc, int'(period8), lock8, tmo8));
      if (tmo8 && !pt8) tmo8_rise.push_back(cyc);
      if ((valid16 && pv16) || (valid8 && pv8)) gap_viol <= gap_viol + 1;
      pv16 <= valid16;
      pv8  <= valid8;
      pt8  <= tmo8;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Lock rule: first period is the reference; later ones within TOL of the previous
   // increment a saturating match count, anything else clears it.
   function automatic bitq_t model_lock(input int p[$]);
      bitq_t lk;
      int    m = 0;
      int    d;
      foreach (p[k]) begin
         if (k == 0) begin
            m = 0;
         end else begin
            d = (p[k] > p[k-1]) ? p[k] - p[k-1] : p[k-1] - p[k];
            if (d <= Tol) m = (m < LockCnt) ? m + 1 : m;
            else m = 0;
         end
         lk.push_back(m == LockCnt);
      end
      return lk;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One rise per listed period plus a closing rise; phases are p/2 high, rest low.
   task automatic drive_periods(input int p[$]);
      foreach (p[k]) begin
         sig = 1'b1;
         repeat (p[k] / 2) @(posedge clk);
         #1 sig = 1'b0;
         repeat (p[k] - p[k] / 2) @(posedge clk);
         #1;
      end
      sig = 1'b1;
      repeat (3) @(posedge clk);
      #1 sig = 1'b0;
   endtask

   task automatic check_obs16(input string tag, input int p[$], input bit lk[$], input int base);
      int n;
      n = obs16.size() - base;
      check({tag, " valid count"}, n, p.size());
      for (int k = 0; k < p.size() && k < n; k++) begin
         check($sformatf("%s period[%0d]", tag, k), obs16[base+k].period, p[k]);
         check($sformatf("%s lock[%0d]", tag, k), obs16[base+k].lock, lk[k]);
         check($sformatf("%s timeout[%0d]", tag, k), obs16[base+k].tmo, 0);
         if (k > 0)
            check($sformatf("%s spacing[%0d]", tag, k),
                  obs16[base+k].cyc - obs16[base+k-1].cyc, p[k]);
      end
   endtask

   task automatic run16(input string tag, input int p[$], input bit lk[$]);
      int base;
      sig = 1'b0;
      do_reset();
      repeat (8) @(posedge clk);
      #1;
      base = obs16.size();
      drive_periods(p);
      repeat (12) @(posedge clk);
      #1;
      check_obs16(tag, p, lk, base);
   endtask

   initial begin
      // Reset state.
      sig = 1'b0;
      do_reset();
      @(negedge clk);
      check("reset O_PERIOD", period16, 0);
      check("reset O_VALID", valid16, 0);
      check("reset O_LOCK", lock16, 0);
      check("reset O_TIMEOUT", tmo16, 0);
      check("reset O_TIMEOUT w8", tmo8, 0);

      // Table: steady 42 (21-cycle toggle), then 42,43,42,41,42,50.
      tbl.push_back(mk_vec(1, 42, 0)); tbl.push_back(mk_vec(0, 42, 0));
      tbl.push_back(mk_vec(0, 42, 0)); tbl.push_back(mk_vec(0, 42, 0));
      tbl.push_back(mk_vec(0, 42, 1)); tbl.push_back(mk_vec(0, 42, 1));
      tbl.push_back(mk_vec(1, 42, 0)); tbl.push_back(mk_vec(0, 43, 0));
      tbl.push_back(mk_vec(0, 42, 0)); tbl.push_back(mk_vec(0, 41, 0));
      tbl.push_back(mk_vec(0, 42, 1)); tbl.push_back(mk_vec(0, 50, 0));
      grp_n = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].restart && grp_p.size() > 0) begin
            run16($sformatf("table%0d", grp_n), grp_p, grp_l);
            grp_n++;
            grp_p = {};
            grp_l = {};
         end
         grp_p.push_back(tbl[i].period);
         grp_l.push_back(tbl[i].exp_lock);
      end
      run16($sformatf("table%0d", grp_n), grp_p, grp_l);

      // Randomized periods: mostly near a base value so lock gets exercised.
      for (int r = 0; r < 6; r++) begin
         int base_p;
         base_p = 20 + int'($urandom_range(0, 60));
         rp = {};
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) rp.push_back(int'($urandom_range(4, 90)));
            else rp.push_back(base_p - 1 + int'($urandom_range(0, 2)));
         end
         run16($sformatf("rand%0d", r), rp, model_lock(rp));
      end

      // Timeout on the W=8 instance after a locked run, then recovery.
      sig = 1'b0;
      do_reset();
      repeat (8) @(posedge clk);
      #1;
      b8 = obs8.size();
      bt = tmo8_rise.size();
      rp = {};
      repeat (6) rp.push_back(40);
      drive_periods(rp);
      repeat (300) @(posedge clk);
      @(negedge clk);
      check("tmo valid count", obs8.size() - b8, 6);
      check("tmo rise count", tmo8_rise.size() - bt, 1);
      if (obs8.size() > b8) check("tmo locked before", obs8[obs8.size()-1].lock, 1);
      if (tmo8_rise.size() > bt && obs8.size() > b8)
         check("tmo rise time", tmo8_rise[bt] - obs8[obs8.size()-1].cyc, 255);
      check("tmo level", tmo8, 1);
      check("tmo lock lost", lock8, 0);
      #1;
      b8 = obs8.size();
      rp = {};
      rp.push_back(30);
      drive_periods(rp);
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("tmo recover count", obs8.size() - b8, 1);
      if (obs8.size() > b8) begin
         check("tmo recover period", obs8[b8].period, 30);
         check("tmo recover cleared", obs8[b8].tmo, 0);
      end
      check("tmo level after", tmo8, 0);
      #1;

      // Period exactly 2^8-1: rise wins over saturation.
      sig = 1'b0;
      do_reset();
      repeat (8) @(posedge clk);
      #1;
      b8  = obs8.size();
      bt  = tmo8_rise.size();
      b16 = obs16.size();
      rp = {};
      repeat (2) rp.push_back(255);
      drive_periods(rp);
      repeat (12) @(posedge clk);
      #1;
      check("sat valid count", obs8.size() - b8, 2);
      for (int k = 0; k < 2 && b8 + k < obs8.size(); k++) begin
         check($sformatf("sat period[%0d]", k), obs8[b8+k].period, 255);
         check($sformatf("sat timeout[%0d]", k), obs8[b8+k].tmo, 0);
      end
      check("sat no timeout", tmo8_rise.size() - bt, 0);
      check_obs16("sat w16", rp, model_lock(rp), b16);

      // Input high through reset: no measurement from the reset edge.
      sig = 1'b1;
      do_reset();
      b16 = obs16.size();
      repeat (10) @(posedge clk);
      #1 sig = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rp = {};
      repeat (3) rp.push_back(10);
      drive_periods(rp);
      repeat (12) @(posedge clk);
      #1;
      check_obs16("held high", rp, model_lock(rp), b16);

      // Reset mid-measurement while locked, then a clean re-measurement.
      sig = 1'b0;
      do_reset();
      repeat (8) @(posedge clk);
      #1;
      rp = {};
      repeat (6) rp.push_back(30);
      drive_periods(rp);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("midrst locked", lock16, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst O_PERIOD", period16, 0);
      check("midrst O_VALID", valid16, 0);
      check("midrst O_LOCK", lock16, 0);
      check("midrst O_TIMEOUT", tmo16, 0);
      #1;
      repeat (8) @(posedge clk);
      #1;
      b16 = obs16.size();
      rp = {};
      repeat (2) rp.push_back(30);
      drive_periods(rp);
      repeat (12) @(posedge clk);
      #1;
      check_obs16("midrst after", rp, model_lock(rp), b16);

      check("no back-to-back O_VALID", gap_viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of a slow, asynchronous square-wave input (typically a divided clock) in cycles of the local clock I_CLK. It synchronizes the input, detects rising edges, and reports each edge-to-edge period with a one-cycle valid strobe. It also reports lock (stable period) and timeout (input stopped). It is the receiving/checking end for divided-clock outputs, used for on-chip frequency checks and for divider self-test.

## Interface
Parameters:
- W, 16: period counter and O_PERIOD width; the maximum measurable period is 2^W-1.
- SYNC_STAGES, 2: number of synchronizer flops on I_SIG; minimum 2.
- LOCK_CNT, 4: number of consecutive matching measurements required for lock.
- TOL, 1: maximum absolute difference, in cycles, between successive periods that still counts as a match.

Ports:
- I_CLK  in  1  sole clock; all logic is on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- I_SIG  in  1  asynchronous signal to measure.
- O_PERIOD  out  W  last measured period in I_CLK cycles; reset value 0.
- O_VALID  out  1  one-cycle strobe; O_PERIOD is new on this cycle. Reset value 0.
- O_LOCK  out  1  period is stable; reset value 0.
- O_TIMEOUT  out  1  no edge seen within 2^W-1 cycles. Level signal; reset value 0.

## Operation
- Front end: I_SIG passes through SYNC_STAGES flops, then a previous-value flop. A rising edge (rise) is the condition sync==1 and prev==1'b0. All synchronizer flops reset to 0.
- FSM states:
  - IDLE: wait for sync==0, then go to ARM. This guarantees that a high I_SIG at reset release never produces a false edge.
  - ARM: on rise, set cnt<=1 and go to MEAS.
  - MEAS, on rise: O_PERIOD<=cnt, O_VALID<=1, O_TIMEOUT<=0, cnt<=1, update the lock logic.
  - MEAS, no rise and cnt==2^W-1: O_TIMEOUT<=1, O_LOCK<=0, match<=0, go to IDLE.
  - MEAS, otherwise: cnt<=cnt+1.
- Period arithmetic: cnt counts from 1. For rises detected on cycles e0 and e1, O_PERIOD = e1-e0. The counter never wraps; saturation at 2^W-1 triggers timeout.
- Simultaneous events: if rise and cnt==2^W-1 occur in the same cycle, rise wins. The block emits a valid measurement of 2^W-1 with no timeout.
- Lock logic:
  - The first measurement after entering MEAS from ARM stores the reference value and sets match=0.
  - Each later measurement compares against the previous one. If |new-prev|<=TOL, match++ (saturating at LOCK_CNT). Otherwise match=0.
  - O_LOCK = (match==LOCK_CNT). It updates on the same cycle as O_VALID.
  - Lock is lost on a mismatch or a timeout.
- Period comparison uses W+1-bit signed difference; no overflow is allowed.
- Reset mid-operation: on the cycle after Rst is sampled high, all outputs are 0, state is IDLE, cnt=0 and match=0. Any partial measurement is discarded.

## Timing
- Input to rise detect latency: SYNC_STAGES+1 cycles. This latency is constant, so it cancels in the period.
- O_VALID and O_PERIOD are registered. They are asserted one cycle after the rise cycle. O_VALID is never high on two consecutive cycles, because the minimum period is 2.
- O_PERIOD holds its value between strobes.
- O_TIMEOUT rises at e0+2^W, where e0 is the last rise cycle. It stays high until the next O_VALID or Rst.
- After reset, the earliest first O_VALID comes after one full input period following the first low-to-high transition.
- Supported input: high and low phases of at least 2 I_CLK cycles each. Shorter phases may be missed; this is not flagged.

## Structure
- Package clk_meter_pkg contains:
  - FSM state encoding: IDLE=2'd0, ARM=2'd1, MEAS=2'd2.
  - Defaults for W, SYNC_STAGES, LOCK_CNT and TOL.
- Sub-module sync_rise_det: parameter SYNC_STAGES; ports I_CLK, Rst, I_SIG, O_SYNC, O_RISE. It is reused by other blocks that need edge detection.
- The top level contains only the FSM, counter, lock comparator and output registers.

## Test plan
- Reset release, then I_SIG toggling every 21 cycles: first O_VALID carries O_PERIOD=42. O_LOCK asserts with the 5th O_VALID (LOCK_CNT=4).
- Periods 42,43,42,41,42 (TOL=1), then one period of 50: O_LOCK=1 after the 5th measurement. O_LOCK drops on the cycle of the O_VALID carrying 50.
- W=8, I_SIG stops toggling after a rise at cycle e0: O_TIMEOUT=1 and O_LOCK=0 at e0+256, and no O_VALID is issued. The next measurement clears O_TIMEOUT.
- I_SIG held high through and after reset, then driven low for 5 cycles and toggled with period 10: no O_VALID from the reset edge. The first O_VALID carries 10.
- W=8, input period exactly 255: O_VALID with O_PERIOD=255 and O_TIMEOUT stays 0 (rise wins over saturation).
- Rst pulsed mid-measurement while locked: all outputs are 0 on the next cycle. The FSM re-arms, and the first post-reset O_VALID reports a full, correct period.
